move_cmd_gen: RTL
=================

# move_cmd_gen

Front-end command source for the 2048 game controller. Conditions four raw direction pushbuttons (synchronize, debounce, edge-detect) and delivers exactly one single-cycle `up`/`down`/`left`/`right` request per press, held off until the game FSM signals it is waiting for a move. Sits between the board pins and the game state machine's direction inputs; `ready` is driven from the controller's WAIT-state flag.

## Interface

- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples required before a debounced level changes (5 ms at 100 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, 25000000: auto-repeat interval; used only with `MOVE_AUTOREPEAT_EN`.
- `CNT_W`, 25: counter width; must hold `max(DEBOUNCE_CYCLES, REPEAT_CYCLES)`.

- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw asynchronous buttons, active-high.
- `ready`  in  1  consumer can accept a move this cycle (game FSM in WAIT).
- `up`, `down`, `left`, `right`  out  1 each  one-cycle move request, registered, at most one high at a time.
- `pending`  out  1  a press is latched and waiting for `ready`.

## Operation

- Per button: two-flop synchronizer `s1 → s2`, debounced level `db`, counter `dcnt`.
- Debounce:
  - `s2 == db`: clear `dcnt`.
  - Otherwise increment `dcnt`. On the edge where `dcnt == DEBOUNCE_CYCLES-1`, toggle `db` and clear `dcnt`.
  - Any single-sample glitch therefore restarts the count.
- Press event: `db & ~db_prev`, per button.
- Priority: among simultaneous press events, up > down > left > right. This matches the consumer's priority. The latched direction is `dir` (2 bits).
- FSM states: IDLE, PEND, FIRE, HOLD.
  - IDLE: on any press event, latch `dir` → PEND. Otherwise stay.
  - PEND: `pending=1`. If `ready`, → FIRE. Otherwise stay indefinitely.
  - FIRE: the output selected by `dir` is high for this one cycle only. → HOLD unconditionally; `ready` is ignored here.
  - HOLD: stay while any `db` is 1. When all `db` are 0, → IDLE.
- Press events in PEND, FIRE or HOLD are discarded, with no queueing. A second button pressed while the first is held yields nothing until all buttons are released.
- Release events never generate commands.

## Timing

- Reset values: all outputs 0; `s1`, `s2`, `db`, `db_prev`, `dcnt`, `rcnt` and `dir` all 0; FSM in IDLE.
- Latency (raw button rises before edge N, stable, `ready` held high):
  - `db` rises at edge N+1+DEBOUNCE_CYCLES.
  - PEND at edge N+2+DEBOUNCE_CYCLES.
  - Output high from edge N+3+DEBOUNCE_CYCLES for exactly one cycle.
- `ready` low: the output fires one cycle after the first cycle `ready` is sampled high in PEND.
- A button held across reset deassertion is treated as a new press and produces one command after debounce.
- Reset asserted mid-operation (any state, including FIRE) clears the outputs immediately; no request is delivered later.
- Outputs are strictly one-hot or all-zero in every cycle.

## Configuration

- `MOVE_AUTOREPEAT_EN` defined:
  - In HOLD, `rcnt` increments while the latched `dir` button's `db` is 1 and all other `db` are 0.
  - Any other `db` pattern clears `rcnt`.
  - When `rcnt == REPEAT_CYCLES-1`, clear `rcnt` and go to PEND with the same `dir`, issuing another move.
  - `rcnt` clears on every entry to HOLD.
- Not defined:
  - `rcnt` is not built; `REPEAT_CYCLES` is ignored.
  - Exactly one command is issued per press.

## Test plan

Bench uses `DEBOUNCE_CYCLES=4`, `REPEAT_CYCLES=10`.

- `btn_left` rises before edge 10 and is held, `ready=1` → `left` is high only in the cycle after edge 17. No other output is ever high. Release → no further pulse.
- `btn_up` toggles every 2 cycles for 20 cycles, then stays low → no output and `db_up` never rises. Then hold high → a single `up` pulse.
- `btn_down` and `btn_right` rise on the same edge → only `down` pulses. Release `down` while `right` is held → no `right` pulse until both are released and `right` is pressed again.
- `ready=0` during the press → `pending=1` stays high. Raise `ready` 50 cycles later → pulse on the next cycle and `pending` drops. Press `btn_up` while PEND with `dir=right` → still a `right` pulse only.
- Assert `Reset` in the PEND cycle → all outputs and `pending` go 0 immediately. Button still held at release → exactly one pulse 4+DEBOUNCE_CYCLES edges after reset release with `ready=1`.
- With `MOVE_AUTOREPEAT_EN` and `btn_right` held 40 cycles past the first pulse → `right` pulses repeat at 12-cycle spacing: `REPEAT_CYCLES` in HOLD, plus one PEND cycle and one FIRE cycle. Without the macro → one pulse only.

Source files
------------

// File: rtl/move_cmd_if.sv
// move_cmd_if: raw buttons and ready in, one-cycle move requests and pending flag out
interface move_cmd_if;
  logic btn_up, btn_down, btn_left, btn_right, ready;
  logic up, down, left, right, pending;
  modport master(output btn_up, btn_down, btn_left, btn_right, ready,
                 input up, down, left, right, pending);
  modport slave(input btn_up, btn_down, btn_left, btn_right, ready,
                output up, down, left, right, pending);
endinterface

// File: rtl/move_cmd_gen.sv
// move_cmd_gen: debounced pushbuttons to one-cycle move requests; MOVE_AUTOREPEAT_EN adds hold-to-repeat
module move_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES = 25000000,
  parameter int CNT_W = 25
) (
  input logic Clk,
  input logic Reset,
  move_cmd_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PEND, FIRE, HOLD} state_t;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [3:0] raw, s1_q, s2_q, db_q, db_d, db_prev_q, press, cmd_q, cmd_d;
  logic [3:0][CNT_W-1:0] dcnt_q, dcnt_d;
  logic [1:0] dir_q, dir_d, press_dir;
  logic pending_q, pending_d;
  state_t state_q, state_d;
`ifdef MOVE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif
  // bit order everywhere: {right, left, down, up}; lower index wins priority
  assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
  assign press = db_q & ~db_prev_q;
  assign press_dir = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
  assign {bus.right, bus.left, bus.down, bus.up} = cmd_q;
  assign bus.pending = pending_q;
  // debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i] = (s2_q[i] != db_q[i] && dcnt_q[i] == DB_LAST) ? ~db_q[i] : db_q[i];
      dcnt_d[i] = (s2_q[i] == db_q[i] || dcnt_q[i] == DB_LAST) ? '0 : dcnt_q[i] + 1'b1;
    end
  end
  // command FSM next state; outputs are computed here so they leave the block registered
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    cmd_d = '0;
    pending_d = 1'b0;
`ifdef MOVE_AUTOREPEAT_EN
    rcnt_d = '0;
`endif
    case (state_q)
      IDLE: begin
        state_d = |press ? PEND : IDLE;
        dir_d = |press ? press_dir : dir_q;
        pending_d = |press;
      end
      PEND: begin
        state_d = bus.ready ? FIRE : PEND;
        cmd_d = bus.ready ? 4'b1 << dir_q : 4'b0;
        pending_d = ~bus.ready;
      end
      FIRE: state_d = HOLD;
      HOLD: begin
`ifdef MOVE_AUTOREPEAT_EN
        if (db_q == 4'b1 << dir_q) begin
          state_d = rcnt_q == RP_LAST ? PEND : HOLD;
          pending_d = rcnt_q == RP_LAST;
          rcnt_d = rcnt_q == RP_LAST ? '0 : rcnt_q + 1'b1;
        end else
          state_d = |db_q ? HOLD : IDLE;
`else
        state_d = |db_q ? HOLD : IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  // all state, including the synchronizers, clears asynchronously so reset kills any in-flight request
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      db_prev_q <= '0;
      dcnt_q <= '0;
      dir_q <= '0;
      cmd_q <= '0;
      pending_q <= 1'b0;
      state_q <= IDLE;
`ifdef MOVE_AUTOREPEAT_EN
      rcnt_q <= '0;
`endif
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      db_q <= db_d;
      db_prev_q <= db_q;
      dcnt_q <= dcnt_d;
      dir_q <= dir_d;
      cmd_q <= cmd_d;
      pending_q <= pending_d;
      state_q <= state_d;
`ifdef MOVE_AUTOREPEAT_EN
      rcnt_q <= rcnt_d;
`endif
    end
  end
endmodule
